// File: rtl/ntsc_composite_encoder.sv
// NTSC composite encoder: quadrature-modulates I/Q onto the subcarrier, adds luma, clamps, and applies sync/burst/blank levels.
// Optional colour-kill input is compiled in when NTSC_COLOR_KILL_EN is defined.
module ntsc_composite_encoder #(
   parameter int PHASE_BITS            = 4,
   parameter int DAC_BITS              = 5,
   parameter int BLANK_LEVEL           = 8,
   parameter int BLACK_LEVEL           = 10,
   parameter int WHITE_LEVEL           = 28,
   parameter int LOWER_SWING_LEVEL     = 4,
   parameter int UPPER_SWING_LEVEL     = 31,
   parameter int BURST_AMPLITUDE_SHIFT = 2,
   parameter int I_PHASE_STEPS         = 5,
   parameter int CHROMA_SHIFT          = 12
) (
   input  logic                  phaseClock,
   input  logic                  reset,
   input  logic [PHASE_BITS-1:0] subcarrierPhase,
   input  logic                  blank,
   input  logic                  sync,
   input  logic                  burst,
   input  logic [7:0]            y,
   input  logic signed [8:0]     i,
   input  logic signed [8:0]     q,
`ifdef NTSC_COLOR_KILL_EN
   input  logic                  colorKill,
`endif
   output logic [DAC_BITS-1:0]   dacSample
);

   localparam int N = 1 << PHASE_BITS;
   localparam logic [PHASE_BITS-1:0] I_OFF = PHASE_BITS'(I_PHASE_STEPS);
   localparam logic [PHASE_BITS-1:0] Q_OFF = PHASE_BITS'(I_PHASE_STEPS - N / 4);
   localparam logic [PHASE_BITS-1:0] B_OFF = PHASE_BITS'(N / 2);

   function automatic logic [N-1:0][7:0] buildCosTable();
      logic [N-1:0][7:0] lut;
      real               value;
      int                rounded;
      for (int k = 0; k < N; k++) begin
         value   = 127.0 * $cos(2.0 * 3.14159265358979323846 * k / N);
         rounded = (value >= 0.0) ? $rtoi(value + 0.5) : $rtoi(value - 0.5);
         lut[k]  = 8'(rounded);
      end
      return lut;
   endfunction

   localparam logic [N-1:0][7:0] COS_LUT = buildCosTable();

   logic [7:0]            yS1_q;
   logic signed [8:0]     iS1_q, qS1_q;
   logic signed [7:0]     cosI_q, cosQ_q, cosB_q;
   logic                  blankS1_q, syncS1_q, burstS1_q, killS1_q;
   logic signed [16:0]    prodI_q, prodQ_q, prodI_d, prodQ_d;
   logic [7:0]            luma_q, luma_d;
   logic signed [7:0]     burstScaled_q, burstScaled_d;
   logic                  blankS2_q, syncS2_q, burstS2_q, killS2_q;
   logic [DAC_BITS-1:0]   dacSample_q, dacSample_d;
   logic                  killIn;
   int                    chroma, activeLevel;

`ifdef NTSC_COLOR_KILL_EN
   assign killIn = colorKill;
`else
   assign killIn = 1'b0;
`endif

   // Stage 1: capture inputs and the three subcarrier samples for this phase.
   always_ff @(posedge phaseClock) begin
      if (reset) begin
         yS1_q     <= '0;
         iS1_q     <= '0;
         qS1_q     <= '0;
         cosI_q    <= '0;
         cosQ_q    <= '0;
         cosB_q    <= '0;
         blankS1_q <= 1'b1;
         syncS1_q  <= 1'b0;
         burstS1_q <= 1'b0;
         killS1_q  <= 1'b0;
      end else begin
         yS1_q     <= y;
         iS1_q     <= i;
         qS1_q     <= q;
         cosI_q    <= signed'(COS_LUT[subcarrierPhase + I_OFF]);
         cosQ_q    <= signed'(COS_LUT[subcarrierPhase + Q_OFF]);
         cosB_q    <= signed'(COS_LUT[subcarrierPhase + B_OFF]);
         blankS1_q <= blank;
         syncS1_q  <= sync;
         burstS1_q <= burst;
         killS1_q  <= killIn;
      end
   end

   always_comb begin
      prodI_d       = iS1_q * cosI_q;
      prodQ_d       = qS1_q * cosQ_q;
      luma_d        = 8'(BLACK_LEVEL + ((int'(yS1_q) * (WHITE_LEVEL - BLACK_LEVEL) + 128) >> 8));
      burstScaled_d = 8'(((int'(cosB_q) <<< BURST_AMPLITUDE_SHIFT) + 64) >>> 7);
   end

   always_ff @(posedge phaseClock) begin
      if (reset) begin
         prodI_q       <= '0;
         prodQ_q       <= '0;
         luma_q        <= '0;
         burstScaled_q <= '0;
         blankS2_q     <= 1'b1;
         syncS2_q      <= 1'b0;
         burstS2_q     <= 1'b0;
         killS2_q      <= 1'b0;
      end else begin
         prodI_q       <= prodI_d;
         prodQ_q       <= prodQ_d;
         luma_q        <= luma_d;
         burstScaled_q <= burstScaled_d;
         blankS2_q     <= blankS1_q;
         syncS2_q      <= syncS1_q;
         burstS2_q     <= burstS1_q;
         killS2_q      <= killS1_q;
      end
   end

   // Stage 3: int-width arithmetic so luma+chroma cannot wrap before the clamp.
   always_comb begin
      chroma = (int'(prodI_q) + int'(prodQ_q) + (1 << (CHROMA_SHIFT - 1))) >>> CHROMA_SHIFT;
      if (killS2_q) chroma = 0;
      activeLevel = int'(luma_q) + chroma;
      if (activeLevel < LOWER_SWING_LEVEL) activeLevel = LOWER_SWING_LEVEL;
      if (activeLevel > UPPER_SWING_LEVEL) activeLevel = UPPER_SWING_LEVEL;
      dacSample_d = DAC_BITS'(activeLevel);
      if (syncS2_q) begin
         dacSample_d = '0;
      end else if (burstS2_q) begin
         dacSample_d = killS2_q ? DAC_BITS'(BLANK_LEVEL)
                                : DAC_BITS'(BLANK_LEVEL + int'(burstScaled_q));
      end else if (blankS2_q) begin
         dacSample_d = DAC_BITS'(BLANK_LEVEL);
      end
   end

   always_ff @(posedge phaseClock) begin
      if (reset) dacSample_q <= DAC_BITS'(BLANK_LEVEL);
      else       dacSample_q <= dacSample_d;
   end

   assign dacSample = dacSample_q;

endmodule

// File: tb/tb_ntsc_composite_encoder.sv
// Directed testbench for ntsc_composite_encoder with hand-computed expected DAC codes (default parameters).
module tb_ntsc_composite_encoder;

   logic              phaseClock = 1'b0;
   logic              reset;
   logic [3:0]        subcarrierPhase;
   logic              blank, sync, burst, colorKill;
   logic [7:0]        y;
   logic signed [8:0] i, q;
   logic [4:0]        dacSample;

   int checks = 0;
   int errors = 0;

   ntsc_composite_encoder dut (
      .phaseClock      (phaseClock),
      .reset           (reset),
      .subcarrierPhase (subcarrierPhase),
      .blank           (blank),
      .sync            (sync),
      .burst           (burst),
      .y               (y),
      .i               (i),
      .q               (q),
`ifdef NTSC_COLOR_KILL_EN
      .colorKill       (colorKill),
`endif
      .dacSample       (dacSample)
   );

   always #5 phaseClock = ~phaseClock;

   // Drive one input vector on the falling edge so it is stable for the next capture edge.
   task automatic applyStimulus(input logic [3:0] p, input logic bl, input logic sy, input logic bu,
                                input logic [7:0] yv, input logic signed [8:0] iv,
                                input logic signed [8:0] qv, input logic kill);
      @(negedge phaseClock);
      subcarrierPhase = p;
      blank = bl;
      sync = sy;
      burst = bu;
      y = yv;
      i = iv;
      q = qv;
      colorKill = kill;
   endtask

   // Capture edge plus two pipeline edges, then sample clear of the edge.
   task automatic waitLatency();
      repeat (3) @(posedge phaseClock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 8'd0, 9'sd0, 9'sd0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         @(posedge phaseClock); #1;
         checks++;
         if (dacSample !== 5'd8) begin
            errors++;
            $display("[TB] FAIL reset_hold%0d got %0d expected 8", c, dacSample);
         end
      end
      @(negedge phaseClock);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge phaseClock); #1;
         checks++;
         if (dacSample !== ((c < 2) ? 5'd8 : 5'd0)) begin
            errors++;
            $display("[TB] FAIL reset_release%0d got %0d expected %0d", c, dacSample, (c < 2) ? 8 : 0);
         end
      end
   endtask

   task automatic test_luma();
      logic [7:0] yVals [3] = '{8'd0, 8'd128, 8'd255};
      logic [4:0] expVals [3] = '{5'd10, 5'd19, 5'd28};
      for (int n = 0; n < 3; n++) begin
         applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, yVals[n], 9'sd0, 9'sd0, 1'b0);
         waitLatency();
         checks++;
         if (dacSample !== expVals[n]) begin
            errors++;
            $display("[TB] FAIL luma_y%0d got %0d expected %0d", yVals[n], dacSample, expVals[n]);
         end
      end
   endtask

   task automatic test_chroma();
      logic [3:0]        pVals [3] = '{4'd11, 4'd3, 4'd11};
      logic signed [8:0] iVals [3] = '{9'sd255, 9'sd255, 9'sd0};
      logic signed [8:0] qVals [3] = '{9'sd0, 9'sd0, 9'sd255};
      logic [4:0]        expVals [3] = '{5'd27, 5'd11, 5'd19};
      for (int n = 0; n < 3; n++) begin
         applyStimulus(pVals[n], 1'b0, 1'b0, 1'b0, 8'd128, iVals[n], qVals[n], 1'b0);
         waitLatency();
         checks++;
         if (dacSample !== expVals[n]) begin
            errors++;
            $display("[TB] FAIL chroma%0d got %0d expected %0d", n, dacSample, expVals[n]);
         end
      end
   endtask

   task automatic test_clamp();
      applyStimulus(4'd11, 1'b0, 1'b0, 1'b0, 8'd255, 9'sd255, 9'sd0, 1'b0);
      waitLatency();
      checks++;
      if (dacSample !== 5'd31) begin
         errors++;
         $display("[TB] FAIL clamp_upper got %0d expected 31", dacSample);
      end
      applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 8'd0, 9'sd255, 9'sd0, 1'b0);
      waitLatency();
      checks++;
      if (dacSample !== 5'd4) begin
         errors++;
         $display("[TB] FAIL clamp_lower got %0d expected 4", dacSample);
      end
   endtask

   task automatic test_burst();
      applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 8'd200, 9'sd100, 9'sd50, 1'b0);
      waitLatency();
      checks++;
      if (dacSample !== 5'd4) begin
         errors++;
         $display("[TB] FAIL burst_p0 got %0d expected 4", dacSample);
      end
      applyStimulus(4'd8, 1'b0, 1'b0, 1'b1, 8'd200, 9'sd100, 9'sd50, 1'b0);
      waitLatency();
      checks++;
      if (dacSample !== 5'd12) begin
         errors++;
         $display("[TB] FAIL burst_p8 got %0d expected 12", dacSample);
      end
   endtask

   task automatic test_priority();
      applyStimulus(4'd8, 1'b1, 1'b1, 1'b1, 8'd255, 9'sd0, 9'sd0, 1'b0);
      waitLatency();
      checks++;
      if (dacSample !== 5'd0) begin
         errors++;
         $display("[TB] FAIL prio_sync got %0d expected 0", dacSample);
      end
      applyStimulus(4'd8, 1'b1, 1'b0, 1'b1, 8'd255, 9'sd0, 9'sd0, 1'b0);
      waitLatency();
      checks++;
      if (dacSample !== 5'd12) begin
         errors++;
         $display("[TB] FAIL prio_burst got %0d expected 12", dacSample);
      end
      applyStimulus(4'd8, 1'b1, 1'b0, 1'b0, 8'd255, 9'sd255, 9'sd0, 1'b0);
      waitLatency();
      checks++;
      if (dacSample !== 5'd8) begin
         errors++;
         $display("[TB] FAIL prio_blank got %0d expected 8", dacSample);
      end
   endtask

   // Consecutive samples with a sync pulse in the middle check control/data alignment.
   task automatic test_back_to_back();
      logic [7:0] yVals [4] = '{8'd0, 8'd128, 8'd0, 8'd255};
      logic       syVals [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [4:0] expVals [4] = '{5'd10, 5'd19, 5'd0, 5'd28};
      for (int c = 0; c < 6; c++) begin
         @(negedge phaseClock);
         if (c < 4) begin
            subcarrierPhase = 4'd0;
            blank = 1'b0;
            burst = 1'b0;
            i = 9'sd0;
            q = 9'sd0;
            colorKill = 1'b0;
            y = yVals[c];
            sync = syVals[c];
         end
         @(posedge phaseClock); #1;
         if (c >= 2) begin
            checks++;
            if (dacSample !== expVals[c-2]) begin
               errors++;
               $display("[TB] FAIL b2b%0d got %0d expected %0d", c - 2, dacSample, expVals[c-2]);
            end
         end
      end
   endtask

   task automatic test_reset_midline();
      applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 8'd255, 9'sd0, 9'sd0, 1'b0);
      repeat (3) @(posedge phaseClock);
      @(negedge phaseClock);
      reset = 1'b1;
      @(posedge phaseClock); #1;
      checks++;
      if (dacSample !== 5'd8) begin
         errors++;
         $display("[TB] FAIL midreset_edge got %0d expected 8", dacSample);
      end
      @(negedge phaseClock);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge phaseClock); #1;
         checks++;
         if (dacSample !== ((c < 2) ? 5'd8 : 5'd28)) begin
            errors++;
            $display("[TB] FAIL midreset_refill%0d got %0d expected %0d", c, dacSample, (c < 2) ? 8 : 28);
         end
      end
   endtask

`ifdef NTSC_COLOR_KILL_EN
   task automatic test_color_kill();
      applyStimulus(4'd11, 1'b0, 1'b0, 1'b0, 8'd128, 9'sd255, 9'sd0, 1'b1);
      waitLatency();
      checks++;
      if (dacSample !== 5'd19) begin
         errors++;
         $display("[TB] FAIL kill_chroma got %0d expected 19", dacSample);
      end
      applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 8'd128, 9'sd0, 9'sd0, 1'b1);
      waitLatency();
      checks++;
      if (dacSample !== 5'd8) begin
         errors++;
         $display("[TB] FAIL kill_burst got %0d expected 8", dacSample);
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      subcarrierPhase = '0;
      blank = 1'b0;
      sync = 1'b0;
      burst = 1'b0;
      colorKill = 1'b0;
      y = '0;
      i = '0;
      q = '0;
      test_reset();
      test_luma();
      test_chroma();
      test_clamp();
      test_burst();
      test_priority();
      test_back_to_back();
      test_reset_midline();
`ifdef NTSC_COLOR_KILL_EN
      test_color_kill();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
